heli_sprite_engine: RTL and testbench

HELI_SPRITE_ENGINE -- requirements
Module: heli_sprite_engine

---
 rtl/heli_sprite_pkg.sv | 59 +++++
 rtl/heli_sprite_rom.sv | 28 ++
 rtl/heli_sprite_engine.sv | 174 +++++++++++++++++
 tb/tb_heli_sprite_engine.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heli_sprite_pkg.sv
// Purpose : shared types, palette colours and bitmap tables for the helicopter sprite engine.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
// Contents: pal_idx_t palette index, WHITE/GREY/RED/BLACK colours, FRAME0_BMP/FRAME1_BMP bitmaps,
//           pal_color() index-to-RGB helper.
package heli_sprite_pkg;

   typedef enum logic [1:0] {
      PAL_TRANSP = 2'd0,
      PAL_WHITE  = 2'd1,
      PAL_GREY   = 2'd2,
      PAL_RED    = 2'd3
   } pal_idx_t;

   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] GREY  = 24'hE0E0E0;
   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] BLACK = 24'h000000;

   // Native bitmap geometry and the index widths needed to address it.
   localparam int BMP_W  = 27;
   localparam int BMP_H  = 15;
   localparam int BMP_XW = 5;
   localparam int BMP_YW = 4;

   typedef logic [BMP_H-1:0][BMP_W-1:0][1:0] bmp_t;

   // Builds one animation frame. The two frames differ only in the rotor row:
   // the alternate frame shows a shorter blade to give the spinning effect.
   function automatic bmp_t build_bmp(input logic alt_rotor);
      bmp_t b;
      b = '0;
      for (int x = 0; x < BMP_W; x++) begin
         if (x >= 6 && (!alt_rotor || (x >= 11 && x <= 21)))
            b[1][x[BMP_XW-1:0]] = PAL_WHITE;
         if (x >= 10)
            b[8][x[BMP_XW-1:0]] = PAL_RED;
         if (x >= 13)
            b[14][x[BMP_XW-1:0]] = PAL_GREY;
      end
      return b;
   endfunction

   localparam bmp_t FRAME0_BMP = build_bmp(1'b0);
   localparam bmp_t FRAME1_BMP = build_bmp(1'b1);

   // Transparent maps to black here; the engine substitutes its own background.
   function automatic logic [23:0] pal_color(input pal_idx_t idx);
      logic [23:0] c;
      case (idx)
         PAL_WHITE: c = WHITE;
         PAL_GREY:  c = GREY;
         PAL_RED:   c = RED;
         default:   c = BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/heli_sprite_rom.sv
// Purpose : combinational bitmap lookup (frame, rx, ry) -> 2-bit palette index.
// Latency : 0 cycles, purely combinational.
// Backpr. : none; output follows inputs.
// Ports   : frame_i animation frame, rx_i/ry_i sprite-relative coordinate (unsigned),
//           idx_o palette index (transparent outside the native bitmap).
module heli_sprite_rom
   import heli_sprite_pkg::*;
#(
   parameter int FRAME_W = 1
) (
   input  logic [FRAME_W-1:0] frame_i,
   input  logic [9:0]         rx_i,
   input  logic [8:0]         ry_i,
   output pal_idx_t           idx_o
);

   always_comb begin
      idx_o = PAL_TRANSP;
      if (rx_i < 10'(BMP_W) && ry_i < 9'(BMP_H)) begin
         // Odd frames use the short-rotor bitmap.
         if (frame_i[0])
            idx_o = pal_idx_t'(FRAME1_BMP[ry_i[BMP_YW-1:0]][rx_i[BMP_XW-1:0]]);
         else
            idx_o = pal_idx_t'(FRAME0_BMP[ry_i[BMP_YW-1:0]][rx_i[BMP_XW-1:0]]);
      end
   end

endmodule

// File: rtl/heli_sprite_engine.sv
// Purpose : overlays an animated helicopter sprite on a pixel scan; emits colour and hit per pixel.
// Latency : 2 cycles from pix_valid to color_valid (S1 offsets/box test, S2 lookup/colour).
// Backpr. : none; accepts one pixel per cycle, output holds colour/hit while idle.
// Ports   : clk/reset_n (async active-low); pix_valid,x_curr,y_curr scan input; vsync_pulse frame strobe;
//           pos_valid,x_pos,y_pos sprite top-left load; color,hit,color_valid registered outputs.
// Option  : define HELI_SPRITE_MIRROR_EN to add input 'mirror' (horizontal flip, latched on vsync_pulse).
module heli_sprite_engine
   import heli_sprite_pkg::*;
#(
   parameter int          SPR_W      = 27,
   parameter int          SPR_H      = 15,
   parameter int          NUM_FRAMES = 2,
   parameter int          FRAME_DIV  = 8,
   parameter logic [23:0] BG_COLOR   = 24'h000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pix_valid,
   input  logic [9:0]  x_curr,
   input  logic [8:0]  y_curr,
   input  logic        vsync_pulse,
   input  logic        pos_valid,
   input  logic [9:0]  x_pos,
   input  logic [8:0]  y_pos,
`ifdef HELI_SPRITE_MIRROR_EN
   input  logic        mirror,
`endif
   output logic [23:0] color,
   output logic        hit,
   output logic        color_valid
);

   localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int DIV_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   // Position / animation state
   logic [9:0]         x_pend_q, x_pend_d, x_act_q, x_act_d;
   logic [8:0]         y_pend_q, y_pend_d, y_act_q, y_act_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   // S1 registers: rx/ry are two's-complement offsets (11/10 bits)
   logic               s1_vld_q;
   logic [10:0]        rx_q, rx_d;
   logic [9:0]         ry_q, ry_d;
   logic               in_box_q, in_box_d;
   logic [FRAME_W-1:0] s1_frame_q;

   // S2 registers
   logic [23:0]        color_q, color_d;
   logic               hit_q, hit_d, color_valid_q, color_valid_d;

   logic [9:0]         rx_lk;
   pal_idx_t           pal_idx;

   // Pending position takes pos_valid at any time; the active copy only moves on
   // vsync so the sprite never tears mid-frame. A simultaneous load bypasses pending.
   always_comb begin
      x_pend_d = x_pend_q;
      y_pend_d = y_pend_q;
      x_act_d  = x_act_q;
      y_act_d  = y_act_q;
      div_d    = div_q;
      frame_d  = frame_q;
      if (pos_valid) begin
         x_pend_d = x_pos;
         y_pend_d = y_pos;
      end
      if (vsync_pulse) begin
         x_act_d = x_pend_d;
         y_act_d = y_pend_d;
         if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            frame_d = (NUM_FRAMES > 1) ? frame_q + 1'b1 : '0;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   // Offsets are computed zero-extended so a sprite near the right/bottom edge
   // clips instead of wrapping onto the left/top of the screen.
   always_comb begin
      rx_d     = {1'b0, x_curr} - {1'b0, x_act_q};
      ry_d     = {1'b0, y_curr} - {1'b0, y_act_q};
      in_box_d = !rx_d[10] && (rx_d[9:0] < 10'(SPR_W)) &&
                 !ry_d[9]  && (ry_d[8:0] < 9'(SPR_H));
   end

`ifdef HELI_SPRITE_MIRROR_EN
   logic mirror_act_q, s1_mirror_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mirror_act_q <= 1'b0;
         s1_mirror_q  <= 1'b0;
      end else begin
         if (vsync_pulse)
            mirror_act_q <= mirror;
         s1_mirror_q <= mirror_act_q;
      end
   end

   // Only meaningful when in_box_q, which guarantees rx < SPR_W.
   assign rx_lk = s1_mirror_q ? (10'(SPR_W - 1) - rx_q[9:0]) : rx_q[9:0];
`else
   assign rx_lk = rx_q[9:0];
`endif

   heli_sprite_rom #(
      .FRAME_W (FRAME_W)
   ) u_rom (
      .frame_i (s1_frame_q),
      .rx_i    (rx_lk),
      .ry_i    (ry_q[8:0]),
      .idx_o   (pal_idx)
   );

   // Idle cycles keep the last colour/hit so downstream sees stable data.
   always_comb begin
      color_d       = color_q;
      hit_d         = hit_q;
      color_valid_d = 1'b0;
      if (s1_vld_q) begin
         color_valid_d = 1'b1;
         if (in_box_q && pal_idx != PAL_TRANSP) begin
            color_d = pal_color(pal_idx);
            hit_d   = 1'b1;
         end else begin
            color_d = BG_COLOR;
            hit_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_pend_q      <= '0;
         y_pend_q      <= '0;
         x_act_q       <= '0;
         y_act_q       <= '0;
         div_q         <= '0;
         frame_q       <= '0;
         s1_vld_q      <= 1'b0;
         rx_q          <= '0;
         ry_q          <= '0;
         in_box_q      <= 1'b0;
         s1_frame_q    <= '0;
         color_q       <= '0;
         hit_q         <= 1'b0;
         color_valid_q <= 1'b0;
      end else begin
         x_pend_q      <= x_pend_d;
         y_pend_q      <= y_pend_d;
         x_act_q       <= x_act_d;
         y_act_q       <= y_act_d;
         div_q         <= div_d;
         frame_q       <= frame_d;
         s1_vld_q      <= pix_valid;
         rx_q          <= rx_d;
         ry_q          <= ry_d;
         in_box_q      <= in_box_d;
         s1_frame_q    <= frame_q;
         color_q       <= color_d;
         hit_q         <= hit_d;
         color_valid_q <= color_valid_d;
      end
   end

   assign color       = color_q;
   assign hit         = hit_q;
   assign color_valid = color_valid_q;

endmodule

// File: tb/tb_heli_sprite_engine.sv
// Purpose : directed self-checking bench for heli_sprite_engine (default parameters).
// Latency : expects color_valid exactly 2 cycles after pix_valid.
// Backpr. : n/a; stimulus is fixed-length, no open-ended waits.
module tb_heli_sprite_engine;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pix_valid;
   logic [9:0]  x_curr;
   logic [8:0]  y_curr;
   logic        vsync_pulse;
   logic        pos_valid;
   logic [9:0]  x_pos;
   logic [8:0]  y_pos;
   logic [23:0] color;
   logic        hit;
   logic        color_valid;
`ifdef HELI_SPRITE_MIRROR_EN
   logic        mirror;
`endif

   int total = 0;
   int bad   = 0;
   int vs_cnt = 0;   // vsyncs since last reset; frame = (vs_cnt / 8) % 2

   typedef struct {
      int          x;
      int          y;
      logic [23:0] c;
      logic        h;
   } vec_t;

   always #5 clk = ~clk;

   heli_sprite_engine dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pix_valid   (pix_valid),
      .x_curr      (x_curr),
      .y_curr      (y_curr),
      .vsync_pulse (vsync_pulse),
      .pos_valid   (pos_valid),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
`ifdef HELI_SPRITE_MIRROR_EN
      .mirror      (mirror),
`endif
      .color       (color),
      .hit         (hit),
      .color_valid (color_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated pixel; returns early color_valid (after 1 edge) and outputs after 2 edges.
   task automatic drive_pix(input int x, input int y, output logic [23:0] c,
                            output logic h, output logic v, output logic v_early);
      x_curr    = 10'(x);
      y_curr    = 9'(y);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      v_early   = color_valid;
      tick();
      c = color;
      h = hit;
      v = color_valid;
   endtask

   task automatic do_vsync(input logic with_pos, input int x, input int y);
      vsync_pulse = 1'b1;
      pos_valid   = with_pos;
      x_pos       = 10'(x);
      y_pos       = 9'(y);
      tick();
      vsync_pulse = 1'b0;
      pos_valid   = 1'b0;
      vs_cnt++;
   endtask

   task automatic load_pos(input int x, input int y);
      pos_valid = 1'b1;
      x_pos     = 10'(x);
      y_pos     = 9'(y);
      tick();
      pos_valid = 1'b0;
   endtask

   task automatic run_vecs(input string name, input vec_t vs[$]);
      logic [23:0] c;
      logic        h, v, ve;
      foreach (vs[i]) begin
         drive_pix(vs[i].x, vs[i].y, c, h, v, ve);
         total++;
         if (ve !== 1'b0) begin
            bad++;
            $display("FAIL %s[%0d] early_valid got=%b want=0", name, i, ve);
         end
         total++;
         if (v !== 1'b1) begin
            bad++;
            $display("FAIL %s[%0d] color_valid got=%b want=1", name, i, v);
         end
         total++;
         if (c !== vs[i].c || h !== vs[i].h) begin
            bad++;
            $display("FAIL %s[%0d] pix(%0d,%0d) got=%h/%b want=%h/%b",
                     name, i, vs[i].x, vs[i].y, c, h, vs[i].c, vs[i].h);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pix_valid = 1'b0; x_curr = '0; y_curr = '0;
      vsync_pulse = 1'b0; pos_valid = 1'b0; x_pos = '0; y_pos = '0;
`ifdef HELI_SPRITE_MIRROR_EN
      mirror = 1'b0;
`endif
      tick();
      tick();
      total++;
      if (color !== 24'h0 || hit !== 1'b0 || color_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%h/%b/%b want=000000/0/0", color, hit, color_valid);
      end
      reset_n = 1'b1;
      vs_cnt  = 0;
      tick();
      total++;
      if (color_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_valid got=%b want=0", color_valid);
      end
   endtask

   task automatic test_basic();
      vec_t vs[$];
      load_pos(100, 50);
      do_vsync(1'b0, 0, 0);
      vs = '{'{116, 51, 24'hFFFFFF, 1'b1},
             '{120, 58, 24'hFF0000, 1'b1},
             '{113, 64, 24'hE0E0E0, 1'b1},
             '{100, 50, 24'h000000, 1'b0},
             '{ 99, 58, 24'h000000, 1'b0},
             '{127, 58, 24'h000000, 1'b0},
             '{126, 58, 24'hFF0000, 1'b1},
             '{112, 64, 24'h000000, 1'b0},
             '{126, 65, 24'h000000, 1'b0},
             '{110, 51, 24'hFFFFFF, 1'b1}};
      run_vecs("basic", vs);
   endtask

   task automatic test_hold();
      logic [23:0] c;
      logic        h, v, ve;
      tick();
      total++;
      if (color_valid !== 1'b0 || color !== 24'hFFFFFF || hit !== 1'b1) begin
         bad++;
         $display("FAIL hold_white got=%h/%b/%b want=ffffff/1/0", color, hit, color_valid);
      end
      drive_pix(100, 50, c, h, v, ve);
      tick();
      tick();
      total++;
      if (color_valid !== 1'b0 || color !== 24'h000000 || hit !== 1'b0) begin
         bad++;
         $display("FAIL hold_bg got=%h/%b/%b want=000000/0/0", color, hit, color_valid);
      end
   endtask

   task automatic test_back_to_back();
      pix_valid = 1'b1; x_curr = 10'd120; y_curr = 9'd58;
      tick();
      x_curr = 10'd100; y_curr = 9'd50;
      tick();
      total++;
      if (color_valid !== 1'b1 || color !== 24'hFF0000 || hit !== 1'b1) begin
         bad++;
         $display("FAIL b2b_a got=%h/%b/%b want=ff0000/1/1", color, hit, color_valid);
      end
      x_curr = 10'd113; y_curr = 9'd64;
      tick();
      total++;
      if (color_valid !== 1'b1 || color !== 24'h000000 || hit !== 1'b0) begin
         bad++;
         $display("FAIL b2b_b got=%h/%b/%b want=000000/0/1", color, hit, color_valid);
      end
      pix_valid = 1'b0;
      tick();
      total++;
      if (color_valid !== 1'b1 || color !== 24'hE0E0E0 || hit !== 1'b1) begin
         bad++;
         $display("FAIL b2b_c got=%h/%b/%b want=e0e0e0/1/1", color, hit, color_valid);
      end
      tick();
      total++;
      if (color_valid !== 1'b0 || color !== 24'hE0E0E0 || hit !== 1'b1) begin
         bad++;
         $display("FAIL b2b_idle got=%h/%b/%b want=e0e0e0/1/0", color, hit, color_valid);
      end
   endtask

   task automatic test_edge();
      vec_t vs[$];
      do_vsync(1'b1, 630, 470);
      vs = '{'{639, 479, 24'h000000, 1'b0},
             '{640, 478, 24'hFF0000, 1'b1},
             '{  0,   0, 24'h000000, 1'b0}};
      run_vecs("edge", vs);
      // Sprite hanging off the right edge must not reappear on the left.
      do_vsync(1'b1, 1010, 50);
      vs = '{'{   3, 58, 24'h000000, 1'b0},
             '{1019, 58, 24'h000000, 1'b0},
             '{1020, 58, 24'hFF0000, 1'b1},
             '{1023, 64, 24'hE0E0E0, 1'b1}};
      run_vecs("nowrap", vs);
   endtask

   task automatic test_pos_pending();
      vec_t vs[$];
      do_vsync(1'b1, 100, 50);
      load_pos(200, 100);
      vs = '{'{120,  58, 24'hFF0000, 1'b1},
             '{220, 108, 24'h000000, 1'b0}};
      run_vecs("pend_old", vs);
      do_vsync(1'b0, 0, 0);
      vs = '{'{220, 108, 24'hFF0000, 1'b1},
             '{120,  58, 24'h000000, 1'b0}};
      run_vecs("pend_new", vs);
      do_vsync(1'b1, 300, 200);
      vs = '{'{320, 208, 24'hFF0000, 1'b1},
             '{220, 108, 24'h000000, 1'b0}};
      run_vecs("pend_same", vs);
   endtask

   task automatic test_frame();
      vec_t vs[$];
      while (vs_cnt % 16 != 0) do_vsync(1'b0, 0, 0);
      vs = '{'{306, 201, 24'hFFFFFF, 1'b1}};
      run_vecs("frame0_start", vs);
      repeat (7) do_vsync(1'b0, 0, 0);
      run_vecs("frame0_div7", vs);
      do_vsync(1'b0, 0, 0);
      vs = '{'{306, 201, 24'h000000, 1'b0},
             '{310, 201, 24'h000000, 1'b0},
             '{311, 201, 24'hFFFFFF, 1'b1},
             '{321, 201, 24'hFFFFFF, 1'b1},
             '{322, 201, 24'h000000, 1'b0},
             '{320, 208, 24'hFF0000, 1'b1}};
      run_vecs("frame1", vs);
      repeat (8) do_vsync(1'b0, 0, 0);
      vs = '{'{306, 201, 24'hFFFFFF, 1'b1},
             '{322, 201, 24'hFFFFFF, 1'b1}};
      run_vecs("frame0_again", vs);
   endtask

   task automatic test_reset_mid();
      vec_t vs[$];
      pix_valid = 1'b1; x_curr = 10'd316; y_curr = 9'd201;
      tick();
      tick();
      tick();
      total++;
      if (color_valid !== 1'b1 || color !== 24'hFFFFFF) begin
         bad++;
         $display("FAIL rmid_pre got=%h/%b want=ffffff/1", color, color_valid);
      end
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if (color !== 24'h0 || hit !== 1'b0 || color_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_async got=%h/%b/%b want=000000/0/0", color, hit, color_valid);
      end
      pix_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      vs_cnt  = 0;
      tick();
      tick();
      total++;
      if (color_valid !== 1'b0 || color !== 24'h0) begin
         bad++;
         $display("FAIL rmid_flush got=%h/%b want=000000/0", color, color_valid);
      end
      vs = '{'{16, 1, 24'hFFFFFF, 1'b1},
             '{10, 8, 24'hFF0000, 1'b1},
             '{ 0, 0, 24'h000000, 1'b0}};
      run_vecs("rmid_post", vs);
   endtask

`ifdef HELI_SPRITE_MIRROR_EN
   task automatic test_mirror();
      vec_t vs[$];
      mirror = 1'b1;
      do_vsync(1'b1, 0, 0);
      mirror = 1'b0;
      vs = '{'{20, 1, 24'hFFFFFF, 1'b1},
             '{ 0, 8, 24'hFF0000, 1'b1},
             '{26, 8, 24'h000000, 1'b0},
             '{26, 1, 24'h000000, 1'b0}};
      run_vecs("mirror_on", vs);
      do_vsync(1'b0, 0, 0);
      vs = '{'{ 0, 8, 24'h000000, 1'b0},
             '{26, 8, 24'hFF0000, 1'b1}};
      run_vecs("mirror_off", vs);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_back_to_back();
      test_edge();
      test_pos_pending();
      test_frame();
      test_reset_mid();
`ifdef HELI_SPRITE_MIRROR_EN
      test_mirror();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
